hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Produces the per-instruction operand-forwarding selects consumed by the Execute stage: forwardAluSrc1, forwardAluSrc2, forwardAx, forwardAy.
- Generates pipeline stall and bubble controls for load-use hazards and for the multi-cycle trigonometry unit.
- Keeps a shadow pipeline of destination and control bits for EXE/MEM/WB and registers its selects, so they are valid during the cycle the instruction occupies EXE.
- Sits between Decode, the Decode/Execute register and the hazard inputs of Fetch.

Parameters:
REG_W, 4, register address width (2**REG_W architectural registers; register 0 reads zero and is never forwarded)
TRIG_LAT, 8, cycles a trig instruction occupies EXE (≥2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dValid  in  1  Decode holds a valid instruction
dRs1  in  REG_W  ALU source 1 register (RD1)
dRs2  in  REG_W  ALU source 2 / store data register (RD2)
dRa0  in  REG_W  Ax source register (R0)
dRa1  in  REG_W  Ay source register (R1)
dRd  in  REG_W  destination register
dRegWrite  in  1  instruction writes dRd
dMemRead  in  1  instruction is a load
dTrig  in  1  instruction uses trig unit (trigControl)
forwardAluSrc1  out  2  select for EXE instr: 00 regfile, 01 WB, 10 MEM
forwardAluSrc2  out  2  same encoding
forwardAx  out  2  same encoding
forwardAy  out  2  same encoding
stallF  out  1  hold PC
stallD  out  1  hold Fetch/Decode register
flushE  out  1  load bubble into Decode/Execute register
stallE  out  1  hold Decode/Execute register (trig busy)
trigBusy  out  1  trig instruction resident in EXE beyond its first cycle

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). On rst: all shadow entries invalid, all forward selects 00, trig counter 0, all stall/flush outputs 0.
- Shadow pipeline: entries E, M, W, each {valid, rd, regWrite, memRead}.
  - Normal advance: W←M, M←E, E←decode fields (valid=dValid).
- Matching: a source matches entry X iff X.valid, X.regWrite, X.rd==src and src!=0.
- Select computation (registered, latched with E):
  - 10 if matches E, else 01 if matches M, else 00.
  - E has priority because it is the youngest producer.
  - The register file is write-through, so W needs no select.
- Load-use: loadUse = dValid and E.memRead and (any of dRs1/dRs2/dRa0/dRa1 matches E).
  - loadUse asserts stallF, stallD, flushE combinationally the same cycle.
  - Next edge: E←bubble (valid=0), selects←00, M/W advance.
  - The instruction re-evaluates the next cycle and then gets select 01 from the load in M→W.
  - Stall lasts exactly one cycle.
- Trig:
  - When E holds a valid dTrig instruction on its first EXE cycle, the counter loads TRIG_LAT-1. The counter decrements each cycle while nonzero.
  - trigBusy = counter!=0. While trigBusy: stallF=stallD=stallE=1, flushE=0, E and the forward selects hold, M←bubble, W←M.
  - The trig unit latches its operands on the first EXE cycle, so held selects are don't-care afterward.
  - Total EXE residency is TRIG_LAT cycles, after which normal advance resumes.
- Simultaneous events: trigBusy has priority over loadUse (loadUse is suppressed while trigBusy). It is re-evaluated on the first non-busy cycle.
- Back-to-back trig: the second trig enters E after the first completes and reloads the counter.
- rst mid-stall or mid-trig: everything returns to reset values on that edge with no residual stall.
- A bubble in E never matches. With dValid=0, no hazard and no stall.
- Outputs stallF/stallD/flushE/stallE/trigBusy are combinational from registered state plus decode inputs. The selects are pure registers.

Decomposition:
- Shared package stages_definition_pkg:
  - enum fwd_sel_t {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}
  - struct shadow_entry_t {valid, rd, regWrite, memRead}
  - constant TRIG_LAT default
- One sub-module, fwd_select, is natural: combinational priority match for one source against E and M returning fwd_sel_t. It is instantiated four times.

Test Plan:
- ADD r3 in decode, then SUB reading r3 as src1 → next EXE cycle forwardAluSrc1=10; one bubble between them → 01; two bubbles → 00.
- LOAD r5 followed immediately by ADD r6=r5+r2 → stallF/stallD/flushE=1 for one cycle, E bubble; ADD then enters EXE with forwardAluSrc1=01, forwardAluSrc2=00.
- Trig instr with TRIG_LAT=8 → stallE/trigBusy high 7 cycles, selects held, M receives 7 bubbles, following instruction enters EXE on cycle 9.
- Writes to r0 by producer and read of r0 as dRa0 → forwardAx=00 always; a producer with regWrite=0 also gives 00.
- LOAD r4 in E while a trig is busy and decode reads r4 → no load-use flush during busy; after busy ends, single load-use stall occurs.
- Assert rst during cycle 3 of a trig stall → next cycle all outputs 0 and selects 00; a subsequent ADD/SUB dependency forwards correctly (10).

Source files
------------

// File: rtl/stages_definition_pkg.sv
// Shared types for the hazard/forwarding unit: forward-select encoding,
// shadow pipeline entry layout and default sizing.
package stages_definition_pkg;

   localparam int unsigned REG_W_DEFAULT    = 4;
   localparam int unsigned TRIG_LAT_DEFAULT = 8;
   // Shadow entries carry a fixed-width rd so the struct is usable for any REG_W up to this.
   localparam int unsigned RD_MAX_W         = 8;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic                valid;
      logic [RD_MAX_W-1:0] rd;
      logic                reg_write;
      logic                mem_read;
   } shadow_entry_t;

   // Register 0 is hardwired to zero, so it never produces a forwarding hit.
   function automatic logic rd_hit(input logic                valid,
                                   input logic                reg_write,
                                   input logic [RD_MAX_W-1:0] rd,
                                   input logic [RD_MAX_W-1:0] src);
      return valid && reg_write && (src != '0) && (rd == src);
   endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority match of one decode source register against the E and M shadow entries.
module fwd_select
   import stages_definition_pkg::*;
#(
   parameter int unsigned REG_W = REG_W_DEFAULT
) (
   input  logic [REG_W-1:0] src,
   input  shadow_entry_t    ent_e,
   input  shadow_entry_t    ent_m,
   output fwd_sel_t         sel_c,
   output logic             load_hit_c
);

   logic hit_e;
   logic hit_m;
   logic unused_m_mem_read;

   assign unused_m_mem_read = ent_m.mem_read;

   assign hit_e = rd_hit(ent_e.valid, ent_e.reg_write, ent_e.rd, RD_MAX_W'(src));
   assign hit_m = rd_hit(ent_m.valid, ent_m.reg_write, ent_m.rd, RD_MAX_W'(src));

   // The producer in E is younger than the one in M, so it wins.
   always_comb begin
      sel_c = FWD_RF;
      if (hit_e) begin
         sel_c = FWD_MEM;
      end else if (hit_m) begin
         sel_c = FWD_WB;
      end
   end

   assign load_hit_c = hit_e & ent_e.mem_read;

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand-forwarding selects for Execute plus load-use and trig-unit
// stall/bubble control, driven from a shadow copy of the EXE/MEM stages.
module hazard_forward_unit
   import stages_definition_pkg::*;
#(
   parameter int unsigned REG_W    = REG_W_DEFAULT,
   parameter int unsigned TRIG_LAT = TRIG_LAT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dValid,
   input  logic [REG_W-1:0] dRs1,
   input  logic [REG_W-1:0] dRs2,
   input  logic [REG_W-1:0] dRa0,
   input  logic [REG_W-1:0] dRa1,
   input  logic [REG_W-1:0] dRd,
   input  logic             dRegWrite,
   input  logic             dMemRead,
   input  logic             dTrig,
   output logic [1:0]       forwardAluSrc1,
   output logic [1:0]       forwardAluSrc2,
   output logic [1:0]       forwardAx,
   output logic [1:0]       forwardAy,
   output logic             stallF,
   output logic             stallD,
   output logic             flushE,
   output logic             stallE,
   output logic             trigBusy
);

   localparam int unsigned CNT_W   = $clog2(TRIG_LAT);
   localparam int unsigned N_SRC   = 4;

   // The register file is write-through, so an entry leaving M has no
   // observable effect here and no WB shadow entry is kept.
   shadow_entry_t   e_q, e_d;
   shadow_entry_t   m_q, m_d;
   shadow_entry_t   dec_ent;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   fwd_sel_t        sel_q [N_SRC];
   fwd_sel_t        sel_d [N_SRC];
   fwd_sel_t        sel_c [N_SRC];
   logic [REG_W-1:0] src [N_SRC];
   logic [N_SRC-1:0] load_hit_c;
   logic            trig_busy;
   logic            load_use;

   assign src[0] = dRs1;
   assign src[1] = dRs2;
   assign src[2] = dRa0;
   assign src[3] = dRa1;

   for (genvar g = 0; g < N_SRC; g++) begin : g_fwd
      fwd_select #(.REG_W(REG_W)) u_fwd (
         .src        (src[g]),
         .ent_e      (e_q),
         .ent_m      (m_q),
         .sel_c      (sel_c[g]),
         .load_hit_c (load_hit_c[g])
      );
   end

   assign dec_ent   = '{dValid, RD_MAX_W'(dRd), dRegWrite, dMemRead};
   assign trig_busy = (cnt_q != '0);
   // A resident trig instruction masks load-use until its last EXE cycle.
   assign load_use  = dValid & ~trig_busy & (|load_hit_c);

   assign stallF   = trig_busy | load_use;
   assign stallD   = trig_busy | load_use;
   assign flushE   = load_use;
   assign stallE   = trig_busy;
   assign trigBusy = trig_busy;

   assign forwardAluSrc1 = sel_q[0];
   assign forwardAluSrc2 = sel_q[1];
   assign forwardAx      = sel_q[2];
   assign forwardAy      = sel_q[3];

   // Next shadow state: hold for trig, bubble for load-use, else advance.
   always_comb begin
      e_d   = e_q;
      m_d   = m_q;
      cnt_d = cnt_q;
      sel_d = sel_q;
      if (trig_busy) begin
         cnt_d = cnt_q - CNT_W'(1);
         m_d   = '0;
      end else if (load_use) begin
         e_d = '0;
         m_d = e_q;
         for (int i = 0; i < N_SRC; i++) begin
            sel_d[i] = FWD_RF;
         end
      end else begin
         e_d   = dec_ent;
         m_d   = e_q;
         sel_d = sel_c;
         if (dValid && dTrig) begin
            cnt_d = CNT_W'(TRIG_LAT - 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e_q   <= '0;
         m_q   <= '0;
         cnt_q <= '0;
         for (int i = 0; i < N_SRC; i++) begin
            sel_q[i] <= FWD_RF;
         end
      end else begin
         e_q   <= e_d;
         m_q   <= m_d;
         cnt_q <= cnt_d;
         sel_q <= sel_d;
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: instruction-level reference model of the
// EXE occupant and its predecessor, directed scenarios, then random traffic.
module tb_hazard_forward_unit;

   localparam int unsigned REG_W    = 4;
   localparam int unsigned TRIG_LAT = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, dValid, dRegWrite, dMemRead, dTrig;
   logic [REG_W-1:0] dRs1, dRs2, dRa0, dRa1, dRd;
   logic [1:0]       forwardAluSrc1, forwardAluSrc2, forwardAx, forwardAy;
   logic             stallF, stallD, flushE, stallE, trigBusy;

   hazard_forward_unit #(.REG_W(REG_W), .TRIG_LAT(TRIG_LAT)) dut (
      .clk(clk), .rst(rst), .dValid(dValid),
      .dRs1(dRs1), .dRs2(dRs2), .dRa0(dRa0), .dRa1(dRa1), .dRd(dRd),
      .dRegWrite(dRegWrite), .dMemRead(dMemRead), .dTrig(dTrig),
      .forwardAluSrc1(forwardAluSrc1), .forwardAluSrc2(forwardAluSrc2),
      .forwardAx(forwardAx), .forwardAy(forwardAy),
      .stallF(stallF), .stallD(stallD), .flushE(flushE), .stallE(stallE),
      .trigBusy(trigBusy)
   );

   typedef struct {
      bit valid;
      int rd;
      bit wr;
      bit ld;
      bit trig;
      int src [4];
   } instr_t;

   // Instruction currently in EXE, the cycle it entered, and its selects.
   typedef struct {
      instr_t   ins;
      int       t0;
      bit       sel_chk;
      bit [1:0] sel [4];
   } occ_t;

   int       n_err = 0;
   int       n_chk = 0;
   int       cyc   = 0;
   bit       model_on = 0;
   bit       e_stall  = 0;
   occ_t     occ;
   instr_t   mem_i;
   string    sel_nm [4] = '{"forwardAluSrc1", "forwardAluSrc2", "forwardAx", "forwardAy"};
   logic [1:0] s_sel [4];
   logic     s_stallF, s_stallD, s_flushE, s_stallE, s_busy;

   function automatic instr_t mk(bit v, int rd, bit wr, bit ld, bit tr,
                                 int s1, int s2, int a0, int a1);
      instr_t x;
      x.valid = v; x.rd = rd; x.wr = wr; x.ld = ld; x.trig = tr;
      x.src[0] = s1; x.src[1] = s2; x.src[2] = a0; x.src[3] = a1;
      return x;
   endfunction

   function automatic instr_t nop();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic occ_t bubble_occ(int t);
      occ_t o;
      o.ins = nop();
      o.t0 = t;
      o.sel_chk = 1;
      for (int i = 0; i < 4; i++) o.sel[i] = 2'b00;
      return o;
   endfunction

   function automatic bit hits(instr_t p, int s);
      return p.valid && p.wr && (p.rd != 0) && (p.rd == s);
   endfunction

   function automatic instr_t rnd();
      return mk($urandom_range(0, 9) < 8, $urandom_range(0, 5), $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                $urandom_range(0, 5), $urandom_range(0, 5),
                $urandom_range(0, 5), $urandom_range(0, 5));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive decode, compare at negedge, advance the model.
   task automatic step(input instr_t in, input bit r);
      bit busy, lu, hit;
      bit [1:0] nsel [4];
      busy = 0; lu = 0; hit = 0;
      rst = r; dValid = in.valid; dRd = REG_W'(in.rd);
      dRegWrite = in.wr; dMemRead = in.ld; dTrig = in.trig;
      dRs1 = REG_W'(in.src[0]); dRs2 = REG_W'(in.src[1]);
      dRa0 = REG_W'(in.src[2]); dRa1 = REG_W'(in.src[3]);
      @(negedge clk);
      s_sel[0] = forwardAluSrc1; s_sel[1] = forwardAluSrc2;
      s_sel[2] = forwardAx;      s_sel[3] = forwardAy;
      s_stallF = stallF; s_stallD = stallD; s_flushE = flushE;
      s_stallE = stallE; s_busy = trigBusy;
      if (model_on) begin
         busy = occ.ins.valid && occ.ins.trig && ((cyc - occ.t0) < (int'(TRIG_LAT) - 1));
         for (int i = 0; i < 4; i++) if (hits(occ.ins, in.src[i])) hit = 1;
         lu = !busy && in.valid && occ.ins.ld && hit;
         chk("stallF", s_stallF, busy || lu);
         chk("stallD", s_stallD, busy || lu);
         chk("flushE", s_flushE, lu);
         chk("stallE", s_stallE, busy);
         chk("trigBusy", s_busy, busy);
         if (occ.sel_chk)
            for (int i = 0; i < 4; i++) chk(sel_nm[i], s_sel[i], occ.sel[i]);
      end
      e_stall = model_on && (busy || lu);
      if (r) begin
         occ = bubble_occ(cyc + 1);
         mem_i = nop();
         model_on = 1;
      end else if (model_on) begin
         if (busy) begin
            mem_i = nop();
         end else if (lu) begin
            mem_i = occ.ins;
            occ = bubble_occ(cyc + 1);
         end else begin
            for (int i = 0; i < 4; i++)
               nsel[i] = hits(occ.ins, in.src[i]) ? 2'b10 :
                         hits(mem_i, in.src[i])   ? 2'b01 : 2'b00;
            mem_i = occ.ins;
            occ.ins = in;
            occ.t0 = cyc + 1;
            occ.sel_chk = in.valid;
            occ.sel = nsel;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      repeat (n) step(nop(), 0);
   endtask

   initial begin
      instr_t add3, sub3, ld5, add6, p9, tr, x, tl, y, cur;
      int nb, ns, nf;
      bit r;

      add3 = mk(1, 3, 1, 0, 0, 1, 2, 0, 0);
      sub3 = mk(1, 4, 1, 0, 0, 3, 1, 0, 0);
      ld5  = mk(1, 5, 1, 1, 0, 1, 0, 0, 0);
      add6 = mk(1, 6, 1, 0, 0, 5, 2, 0, 0);
      p9   = mk(1, 9, 1, 0, 0, 0, 0, 0, 0);
      tr   = mk(1, 7, 1, 0, 1, 1, 2, 0, 0);
      x    = mk(1, 8, 1, 0, 0, 7, 9, 0, 0);
      tl   = mk(1, 4, 1, 1, 1, 0, 0, 0, 0);
      y    = mk(1, 11, 1, 0, 0, 0, 0, 4, 0);

      step(nop(), 1);
      step(nop(), 1);
      chk("rst_sel1", s_sel[0], 2'b00);
      chk("rst_stallF", s_stallF, 0);
      drain(2);

      // Dependency distance 1, 2, 3.
      step(add3, 0); step(sub3, 0); step(nop(), 0);
      chk("fwd_from_e", s_sel[0], 2'b10);
      drain(3);
      step(add3, 0); step(nop(), 0); step(sub3, 0); step(nop(), 0);
      chk("fwd_from_m", s_sel[0], 2'b01);
      drain(3);
      step(add3, 0); step(nop(), 0); step(nop(), 0); step(sub3, 0); step(nop(), 0);
      chk("fwd_none", s_sel[0], 2'b00);
      drain(3);

      // Load-use.
      step(ld5, 0); step(add6, 0);
      chk("lu_stallF", s_stallF, 1);
      chk("lu_flushE", s_flushE, 1);
      chk("lu_stallE", s_stallE, 0);
      step(add6, 0);
      chk("lu_one_cycle", s_stallD, 0);
      step(nop(), 0);
      chk("lu_src1", s_sel[0], 2'b01);
      chk("lu_src2", s_sel[1], 2'b00);
      drain(3);

      // Trig residency.
      step(p9, 0); step(tr, 0);
      nb = 0; ns = 0;
      for (int k = 0; k < 20; k++) begin
         step(x, 0);
         if (s_busy === 1'b1) nb++;
         if (s_stallE === 1'b1) ns++;
         if (s_stallD !== 1'b1) break;
      end
      chk("trig_busy_cycles", nb, 7);
      chk("trig_stallE_cycles", ns, 7);
      step(nop(), 0);
      chk("trig_next_fwd", s_sel[0], 2'b10);
      chk("trig_m_bubbles", s_sel[1], 2'b00);
      drain(3);

      // Register 0 and non-writing producers.
      step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0), 0);
      step(mk(1, 10, 1, 0, 0, 0, 0, 0, 0), 0);
      step(nop(), 0);
      chk("r0_ax", s_sel[2], 2'b00);
      step(mk(1, 2, 0, 0, 0, 0, 0, 0, 0), 0);
      step(mk(1, 10, 1, 0, 0, 0, 0, 2, 0), 0);
      step(nop(), 0);
      chk("nowrite_ax", s_sel[2], 2'b00);
      step(mk(1, 2, 1, 0, 0, 0, 0, 0, 0), 0);
      step(mk(1, 10, 1, 0, 0, 0, 0, 0, 2), 0);
      step(nop(), 0);
      chk("ay_from_e", s_sel[3], 2'b10);
      drain(3);

      // Trig load masks load-use until its last cycle.
      step(tl, 0);
      nb = 0; nf = 0;
      for (int k = 0; k < 20; k++) begin
         step(y, 0);
         if (s_busy === 1'b1) nb++;
         if (s_flushE === 1'b1) nf++;
         if (s_stallD !== 1'b1) break;
      end
      chk("tl_busy_cycles", nb, 7);
      chk("tl_flush_count", nf, 1);
      step(nop(), 0);
      chk("tl_ax_fwd", s_sel[2], 2'b01);
      drain(3);

      // Reset mid-trig.
      step(tr, 0); step(x, 0); step(x, 0); step(x, 1);
      step(nop(), 0);
      chk("mrst_stallF", s_stallF, 0);
      chk("mrst_stallE", s_stallE, 0);
      chk("mrst_busy", s_busy, 0);
      chk("mrst_flushE", s_flushE, 0);
      chk("mrst_sel1", s_sel[0], 2'b00);
      chk("mrst_ax", s_sel[2], 2'b00);
      step(add3, 0); step(sub3, 0); step(nop(), 0);
      chk("mrst_fwd", s_sel[0], 2'b10);
      drain(2);

      // Random traffic; a stalled decode re-presents the same instruction.
      cur = nop();
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 199) == 0);
         if (!e_stall) cur = rnd();
         step(cur, r);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
